// File: rtl/bpred_fetch_unit.sv
// IF-stage PC generator with a direct-mapped BTB of 2-bit saturating counters.
// Define BPRED_FETCH_BTB_EN to build the BTB; otherwise the block is static not-taken with redirect on mispredict.
module bpred_fetch_unit #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     DEPTH    = 16,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic            stall_i,
  input  logic            br_valid_i,
  input  logic [XLEN-1:0] br_pc_i,
  input  logic            br_taken_i,
  input  logic [XLEN-1:0] br_target_i,
  input  logic            br_pred_taken_i,
  input  logic [XLEN-1:0] br_pred_target_i,
  output logic [XLEN-1:0] pc_o,
  output logic            pred_taken_o,
  output logic [XLEN-1:0] pred_target_o,
  output logic            flush_o
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned TAG_W = XLEN - IDX_W - 2;

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] br_plus4;
  logic            mis;
  logic            lk_taken;
  logic [XLEN-1:0] lk_target;

  assign pc_plus4 = pc_q + XLEN'(4);
  assign br_plus4 = br_pc_i + XLEN'(4);

  assign mis = br_valid_i &
               ((br_taken_i != br_pred_taken_i) |
                (br_taken_i & (br_target_i != br_pred_target_i)));

`ifdef BPRED_FETCH_BTB_EN
  logic [DEPTH-1:0] valid_q;
  logic [1:0]       ctr_q [DEPTH];
  logic [TAG_W-1:0] tag_q [DEPTH];
  logic [XLEN-1:0]  tgt_q [DEPTH];

  logic [IDX_W-1:0] lk_idx, up_idx;
  logic [TAG_W-1:0] lk_tag, up_tag;
  logic             lk_hit, up_hit;

  assign lk_idx = pc_q[IDX_W+1:2];
  assign lk_tag = pc_q[XLEN-1:IDX_W+2];
  assign up_idx = br_pc_i[IDX_W+1:2];
  assign up_tag = br_pc_i[XLEN-1:IDX_W+2];

  // Lookup reads pre-update contents; a same-index update lands on the next edge.
  assign lk_hit    = valid_q[lk_idx] & (tag_q[lk_idx] == lk_tag);
  assign up_hit    = valid_q[up_idx] & (tag_q[up_idx] == up_tag);
  assign lk_taken  = lk_hit & ctr_q[lk_idx][1];
  assign lk_target = lk_hit ? tgt_q[lk_idx] : pc_plus4;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      valid_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        ctr_q[i] <= 2'b01;
        tag_q[i] <= '0;
        tgt_q[i] <= '0;
      end
    end else if (br_valid_i && start_i) begin
      if (up_hit) begin
        if (br_taken_i) begin
          if (ctr_q[up_idx] != 2'b11) ctr_q[up_idx] <= ctr_q[up_idx] + 2'd1;
          tgt_q[up_idx] <= br_target_i;
        end else if (ctr_q[up_idx] != 2'b00) begin
          ctr_q[up_idx] <= ctr_q[up_idx] - 2'd1;
        end
      end else if (br_taken_i) begin
        valid_q[up_idx] <= 1'b1;
        tag_q[up_idx]   <= up_tag;
        tgt_q[up_idx]   <= br_target_i;
        ctr_q[up_idx]   <= 2'b10;
      end
    end
  end
`else
  assign lk_taken  = 1'b0;
  assign lk_target = pc_plus4;
`endif

  always_comb begin
    pc_d = pc_q;
    if (!start_i)      pc_d = pc_q;
    else if (mis)      pc_d = br_taken_i ? br_target_i : br_plus4;
    else if (stall_i)  pc_d = pc_q;
    else if (lk_taken) pc_d = lk_target;
    else               pc_d = pc_plus4;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) pc_q <= RESET_PC;
    else        pc_q <= pc_d;
  end

  // Prediction and flush read as zero while reset is held.
  assign pc_o          = pc_q;
  assign pred_taken_o  = rst_i & lk_taken;
  assign pred_target_o = rst_i ? lk_target : '0;
  assign flush_o       = rst_i & mis;

endmodule
